// File: rtl/instr_loader.sv
// instr_loader: assembles a framed byte stream into 32-bit instruction words
// and writes them into instruction memory, then signals the CPU to start.
//
// Frame: 0xFE, N (1..64), N*4 data bytes (MSB first), 0xFF.
//
// Ports:
//   clk_i        in   1   clock, rising-edge
//   reset        in   1   synchronous reset, active-high
//   instr_i      in   8   byte stream, one byte per clock, no strobe
//   imem_we      out  1   one-cycle write pulse per assembled word
//   imem_addr    out  6   word address of the current write
//   imem_wdata   out  32  assembled word
//   cpu_start    out  1   one-cycle pulse on error-free completion
//   load_done    out  1   set on completion, cleared by next 0xFE or reset
//   load_err     out  1   sticky framing error, cleared only by reset
//   words_loaded out  7   words written in the current/most recent load
module instr_loader (
  input  logic        clk_i,
  input  logic        reset,
  input  logic [7:0]  instr_i,
  output logic        imem_we,
  output logic [5:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_start,
  output logic        load_done,
  output logic        load_err,
  output logic [6:0]  words_loaded
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_END   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  logic [2:0]  r_state;
  logic [31:0] r_asm;
  logic [1:0]  r_idx;
  logic [6:0]  r_count;
  logic [6:0]  r_words;
  logic        r_we;
  logic [5:0]  r_addr;
  logic [31:0] r_wdata;
  logic        r_start;
  logic        r_done;
  logic        r_err;

  logic [31:0] w_next_asm;
  logic [6:0]  w_words_inc;
  logic        w_count_ok;

  assign w_next_asm  = {r_asm[23:0], instr_i};
  assign w_words_inc = r_words + 7'd1;
  assign w_count_ok  = (instr_i >= 8'd1) && (instr_i <= 8'd64);

  always_ff @(posedge clk_i) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_asm   <= '0;
      r_idx   <= '0;
      r_count <= '0;
      r_words <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we    <= 1'b0;
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_i == 8'hFE) r_state <= S_COUNT;
        end
        S_COUNT: begin
          if (w_count_ok) begin
            r_count <= instr_i[6:0];
            r_words <= '0;
            r_idx   <= '0;
            r_asm   <= '0;
            r_state <= S_DATA;
          end else begin
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end
        end
        S_DATA: begin
          // Every byte here is payload, including 0xFE/0xFF.
          r_asm <= w_next_asm;
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            // Address is the pre-increment count; counter and pulse land together.
            r_we    <= 1'b1;
            r_wdata <= w_next_asm;
            r_addr  <= r_words[5:0];
            r_words <= w_words_inc;
            if (w_words_inc == r_count) r_state <= S_END;
          end
        end
        S_END: begin
          if (instr_i == 8'hFF) begin
            r_start <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end
        end
        S_DONE: begin
          if (instr_i == 8'hFE) begin
            r_done  <= 1'b0;
            r_state <= S_COUNT;
          end
        end
        S_ERR: begin
          r_err <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign cpu_start    = r_start;
  assign load_done    = r_done;
  assign load_err     = r_err;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a frame-level reference model predicts
// writes and start pulses; a monitor on the falling edge checks the DUT.
module tb_instr_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  instr_i;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_start;
  logic        load_done;
  logic        load_err;
  logic [6:0]  words_loaded;

  instr_loader dut (
    .clk_i       (clk),
    .reset       (reset),
    .instr_i     (instr_i),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_start   (cpu_start),
    .load_done   (load_done),
    .load_err    (load_err),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    int          words;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_start[$];

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  // Reference model: tracks where we are in the frame by phase name.
  typedef enum int {P_WAIT_START, P_WAIT_COUNT, P_PAYLOAD, P_WAIT_END, P_LOADED, P_FAILED} phase_t;
  phase_t   m_phase;
  int       m_n;
  int       m_words;
  bit       m_done;
  bit       m_err;
  logic [7:0] m_bytes[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_WAIT_START;
    m_n     = 0;
    m_words = 0;
    m_done  = 0;
    m_err   = 0;
    m_bytes.delete();
  endtask

  task automatic model_step(input logic [7:0] b);
    wr_t w;
    case (m_phase)
      P_WAIT_START: if (b == 8'hFE) m_phase = P_WAIT_COUNT;
      P_WAIT_COUNT: begin
        if (b >= 1 && b <= 64) begin
          m_n = b; m_words = 0; m_bytes.delete(); m_phase = P_PAYLOAD;
        end else begin
          m_err = 1; m_phase = P_FAILED;
        end
      end
      P_PAYLOAD: begin
        m_bytes.push_back(b);
        if (m_bytes.size() == 4) begin
          w.addr  = m_words[5:0];
          w.data  = (32'(m_bytes[0]) << 24) | (32'(m_bytes[1]) << 16) |
                    (32'(m_bytes[2]) << 8) | 32'(m_bytes[3]);
          w.words = m_words + 1;
          exp_wr.push_back(w);
          m_words++;
          m_bytes.delete();
          if (m_words == m_n) m_phase = P_WAIT_END;
        end
      end
      P_WAIT_END: begin
        if (b == 8'hFF) begin
          m_done = 1; exp_start.push_back(m_words); m_phase = P_LOADED;
        end else begin
          m_err = 1; m_phase = P_FAILED;
        end
      end
      P_LOADED: if (b == 8'hFE) begin m_done = 0; m_phase = P_WAIT_COUNT; end
      default: ;
    endcase
  endtask

  task automatic send(input logic [7:0] b);
    instr_i = b;
    @(posedge clk);
    model_step(b);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    instr_i = 8'($urandom);
    @(posedge clk);
    model_reset();
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    chk("rst_we",    64'(imem_we),    64'd0);
    chk("rst_start", 64'(cpu_start),  64'd0);
    chk("rst_addr",  64'(imem_addr),  64'd0);
    chk("rst_wdata", 64'(imem_wdata), 64'd0);
  endtask

  task automatic send_list(input logic [7:0] bs[$]);
    foreach (bs[i]) send(bs[i]);
  endtask

  // Monitor: every falling edge, compare pulses against the scoreboard and
  // level outputs against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      wr_t w;
      int  s;
      chk("we_start_exclusive", 64'(imem_we & cpu_start), 64'd0);
      chk("write_pulse", 64'(imem_we), 64'(exp_wr.size() != 0));
      if (imem_we === 1'b1 && exp_wr.size() != 0) begin
        w = exp_wr.pop_front();
        chk("write_addr",  64'(imem_addr),    64'(w.addr));
        chk("write_data",  64'(imem_wdata),   64'(w.data));
        chk("write_count", 64'(words_loaded), 64'(w.words));
      end
      chk("start_pulse", 64'(cpu_start), 64'(exp_start.size() != 0));
      if (cpu_start === 1'b1 && exp_start.size() != 0) begin
        s = exp_start.pop_front();
        chk("start_count", 64'(words_loaded), 64'(s));
      end
      chk("load_done",    64'(load_done),    64'(m_done));
      chk("load_err",     64'(load_err),     64'(m_err));
      chk("words_loaded", 64'(words_loaded), 64'(m_words));
    end
  end

  initial begin
    logic [7:0] q[$];
    int n;
    reset   = 1'b1;
    instr_i = 8'h00;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Basic two-word load with leading filler.
    send_list('{8'h00, 8'h00, 8'hFE, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF});
    send(8'h00);
    chk("basic_done", 64'(load_done), 64'd1);

    // Markers inside payload are data.
    do_reset();
    send_list('{8'hFE, 8'h01, 8'hFE, 8'hFF, 8'hFE, 8'hFF, 8'hFF});
    send(8'h00);

    // Count zero, then sticky error ignores a later frame.
    do_reset();
    send_list('{8'hFE, 8'h00, 8'hFE, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF});
    chk("err_cnt0", 64'(load_err), 64'd1);

    // Count 65.
    do_reset();
    send_list('{8'hFE, 8'h41, 8'hFE, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF});
    chk("err_cnt65", 64'(load_err), 64'd1);

    // Bad end byte after one committed word.
    do_reset();
    send_list('{8'hFE, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'hFF});
    chk("bad_end_words", 64'(words_loaded), 64'd1);

    // Full 64-word load.
    do_reset();
    send(8'hFE);
    send(8'h40);
    for (int i = 0; i < 256; i++) send(8'($urandom));
    send(8'hFF);
    send(8'h00);
    chk("full_words", 64'(words_loaded), 64'd64);

    // Reset mid-frame, then a clean frame, then reload from DONE.
    do_reset();
    send_list('{8'hFE, 8'h02, 8'h11, 8'h22});
    do_reset();
    send_list('{8'hFE, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'h00});
    send(8'hFE);
    chk("reload_clears_done", 64'(load_done), 64'd0);
    send_list('{8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'hFF});

    // Randomised frames with occasional corruption and resets.
    for (int it = 0; it < 40; it++) begin
      if (m_err || $urandom_range(0, 9) == 0) do_reset();
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) send(8'($urandom_range(0, 2) == 0 ? 8'hFE : 8'($urandom)));
      send(8'hFE);
      n = ($urandom_range(0, 14) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(65, 255))
                                       : $urandom_range(1, 8);
      send(8'(n));
      for (int i = 0; i < 4 * n && i < 40; i++) begin
        if ($urandom_range(0, 5) == 0) send(($urandom_range(0, 1) == 0) ? 8'hFE : 8'hFF);
        else send(8'($urandom));
      end
      send(($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 254)) : 8'hFF);
    end

    send(8'h00);
    send(8'h00);
    chk("wr_queue_drained",    64'(exp_wr.size()),    64'd0);
    chk("start_queue_drained", 64'(exp_start.size()), 64'd0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk_i  input  1  clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous reset, active-high.
REQ-004 instr_i  input  8  byte stream, one byte sampled per rising edge of clk_i; no valid strobe.
REQ-005 imem_we  output  1  instruction-memory write enable, one-cycle pulse per assembled word.
REQ-006 imem_addr  output  6  word address of the current write, 0..63.
REQ-007 imem_wdata  output  32  assembled instruction word.
REQ-008 cpu_start  output  1  one-cycle pulse when a load completes without error.
REQ-009 load_done  output  1  level; set on successful completion, held until the next 0xFE or reset.
REQ-010 load_err  output  1  level; sticky framing error, cleared only by reset.
REQ-011 words_loaded  output  7  number of words written in the current or most recent load, 0..64.

Function
REQ-012 Frame format SHALL be: start byte 0xFE, count byte N (1..64), then N*4 data bytes, then end byte 0xFF.
REQ-013 Each word SHALL be assembled MSB-first: the first byte of a group goes to bits [31:24] and the fourth byte to bits [7:0].
REQ-014 States SHALL be IDLE, COUNT, DATA, END, DONE and ERR.
REQ-015 IDLE: 0xFE goes to COUNT; every other byte, including 0x00 filler, is ignored.
REQ-016 COUNT: N in 1..64 latches N, clears words_loaded and the byte index, and goes to DATA.
REQ-017 COUNT: N = 0 or N > 64 goes to ERR.
REQ-018 DATA: each sampled byte is shifted into a 32-bit assembly register, and a 2-bit byte index advances modulo 4.
REQ-019 DATA: 0xFE and 0xFF are treated as plain data and are never markers.
REQ-020 When the 4th byte of a word is sampled, imem_we SHALL be 1 in the following cycle, with imem_wdata = the assembled word and imem_addr = words_loaded before the increment.
REQ-021 words_loaded SHALL increment in the same cycle that imem_we is asserted.
REQ-022 After the N-th word's 4th byte is sampled, the FSM goes to END.
REQ-023 END: byte 0xFF goes to DONE, asserts cpu_start for exactly one cycle, and sets load_done.
REQ-024 END: any other byte goes to ERR, and cpu_start stays 0.
REQ-025 DONE: 0xFE clears load_done and goes to COUNT (reload); all other bytes are ignored.
REQ-026 ERR: all bytes are ignored, load_err = 1, and no further imem_we or cpu_start is produced until reset.
REQ-027 Any write already committed before an error SHALL NOT be retracted; words_loaded keeps its value.
REQ-028 imem_addr SHALL never exceed 63; this is guaranteed by the count check in COUNT.
REQ-029 imem_we and cpu_start SHALL never be asserted in the same cycle.
REQ-030 cpu_start SHALL be asserted at least one cycle after the last imem_we.
REQ-031 Latency from the 0xFF being sampled to cpu_start = 1 SHALL be one cycle.
REQ-032 Outputs SHALL be registered; no combinational path from instr_i to any output.

Reset
REQ-033 With reset = 1 at a rising edge, the FSM SHALL enter IDLE, and that byte is not interpreted.
REQ-034 Reset values: imem_we=0, imem_addr=0, imem_wdata=0, cpu_start=0, load_done=0, load_err=0, words_loaded=0, assembly register=0, byte index=0.
REQ-035 Reset mid-frame SHALL abandon the frame with no further writes, and the next frame SHALL load correctly.

Verification
REQ-036 Bytes 00,00,FE,02,11,22,33,44,AA,BB,CC,DD,FF -> two write pulses: addr 0 data 0x11223344, addr 1 data 0xAABBCCDD; cpu_start pulses once, one cycle after FF; load_done=1; words_loaded=2.
REQ-037 Bytes FE,01,FE,FF,FE,FF,FF -> one write: addr 0 data 0xFEFFFEFF; load completes; confirms markers are ignored inside DATA.
REQ-038 Bytes FE,00, and separately after reset FE,41 -> load_err=1 in each case with no imem_we, and subsequent bytes FE,01,... produce no writes.
REQ-039 Bytes FE,01,12,34,56,78,00 -> one write of 0x12345678, then load_err=1, cpu_start never asserted, words_loaded=1.
REQ-040 Full load: FE,40, then 256 bytes, then FF -> 64 writes at addr 0..63 in order; words_loaded=64; cpu_start once.
REQ-041 Reset asserted after FE,02,11,22 -> no write occurs; after reset, a complete frame FE,01,01,02,03,04,FF writes 0x01020304 at addr 0; then FE in DONE clears load_done and restarts.
